gcd_arbiter: RTL

Shares one iterative GCD engine between N requesters, such as button/switch front-ends or a host port. It holds the round-robin grant, latches the granted operands and drives the engine's start/done handshake. It short-circuits trivial zero-operand jobs and returns the result with a one-cycle acknowledge. A watchdog aborts engine jobs that never complete. It sits between the requester logic and the GCD core; LED/display logic consumes resp_data.

---
 rtl/gcd_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one iterative GCD engine among N requesters.
// Latency: zero-operand job acks the cycle after grant; engine job acks one cycle after eng_done.
// Backpressure: req is level-held until its ack; one job in flight, others wait for the next IDLE.
module gcd_arbiter #(
   parameter int N       = 2,
   parameter int W       = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       a_in,
   input  logic [N*W-1:0]       b_in,
   output logic [N-1:0]         ack,
   output logic [W-1:0]         resp_data,
   output logic                 resp_err,
   output logic [$clog2(N)-1:0] resp_id,
   output logic                 busy,
   output logic                 eng_start,
   output logic [W-1:0]         eng_a,
   output logic [W-1:0]         eng_b,
   input  logic                 eng_done,
   input  logic [W-1:0]         eng_result
);

   localparam int IW = $clog2(N);
   localparam logic [N-1:0] ONE_HOT0 = N'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  id_q, id_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [15:0]    wd_q, wd_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [W-1:0]   resp_data_q, resp_data_d;
   logic           resp_err_q, resp_err_d;
   logic [IW-1:0]  resp_id_q, resp_id_d;
   logic           eng_start_q, eng_start_d;
   logic           busy_q, busy_d;

   logic           gnt_vld;
   logic [IW-1:0]  gnt_idx;
   logic [W-1:0]   gnt_a;
   logic [W-1:0]   gnt_b;

   // Round-robin pick: first asserted req at or after ptr, wrapping modulo N.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (!gnt_vld && req[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      gnt_a = a_in[gnt_idx*W +: W];
      gnt_b = b_in[gnt_idx*W +: W];
   end

   // Next-state and registered-output values; outputs default to idle/zero every cycle.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      wd_d        = wd_q;
      ack_d       = '0;
      resp_data_d = '0;
      resp_err_d  = 1'b0;
      resp_id_d   = '0;
      eng_start_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            wd_d = '0;
            if (gnt_vld) begin
               id_d  = gnt_idx;
               a_d   = gnt_a;
               b_d   = gnt_b;
               ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
               if (gnt_a == '0 || gnt_b == '0) begin
                  // Trivial job: gcd(0,x)=x, answered without the engine.
                  state_d     = S_RESP;
                  ack_d       = ONE_HOT0 << gnt_idx;
                  resp_data_d = (gnt_a == '0) ? gnt_b : gnt_a;
                  resp_id_d   = gnt_idx;
               end else begin
                  state_d     = S_ISSUE;
                  eng_start_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + 16'd1;
            // eng_done takes priority over a watchdog expiry in the same cycle.
            if (eng_done) begin
               state_d     = S_RESP;
               ack_d       = ONE_HOT0 << id_q;
               resp_data_d = eng_result;
               resp_id_d   = id_q;
            end else if (wd_q + 16'd1 == 16'(TIMEOUT)) begin
               state_d     = S_RESP;
               ack_d       = ONE_HOT0 << id_q;
               resp_err_d  = 1'b1;
               resp_id_d   = id_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset drops any in-flight job silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         wd_q        <= '0;
         ack_q       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         resp_id_q   <= '0;
         eng_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         wd_q        <= wd_d;
         ack_q       <= ack_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         resp_id_q   <= resp_id_d;
         eng_start_q <= eng_start_d;
         busy_q      <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign resp_data = resp_data_q;
   assign resp_err  = resp_err_q;
   assign resp_id   = resp_id_q;
   assign busy      = busy_q;
   assign eng_start = eng_start_q;
   assign eng_a     = a_q;
   assign eng_b     = b_q;

endmodule
